// File: rtl/multicycle_ctrl_fsm.sv
// Control sequencer for the multi-cycle RV64I datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// the datapath strobes. The datapath owns the instruction register; this block
// keeps only a copy of opcode/funct3 so its later states know what to do.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             illegal_instr,
  output logic [CNT_W-1:0] retired_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  state_t     state_q;
  state_t     state_next;
  logic [6:0] op_q;
  logic [2:0] f3_q;
  logic       retire;

  // Only beq/bne are implemented among the branches; everything else traps.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE: ok = 1'b1;
      OP_BRANCH:                     ok = (f3 == F3_BEQ) || (f3 == F3_BNE);
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State register; reset is asynchronous so outstanding requests drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Capture opcode/funct3 in DECODE so EXEC/MEM/WB see a stable instruction class.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q <= 7'd0;
      f3_q <= 3'd0;
    end else if (state_q == DECODE) begin
      op_q <= opcode;
      f3_q <= funct3;
    end
  end

  // Retired-instruction counter; wraps silently at the top of its range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + 1'b1;
    end
  end

  // Next-state and strobe decode; every output defaults low so unlisted ones stay 0.
  always_comb begin
    state_next    = IDLE;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    illegal_instr = 1'b0;
    retire        = 1'b0;

    case (state_q)
      IDLE: begin
        state_next = FETCH;
      end

      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          state_next = DECODE;
        end else begin
          state_next = FETCH;
        end
      end

      DECODE: begin
        if (is_legal(opcode, funct3)) begin
          state_next = EXEC;
        end else begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
          state_next    = FETCH;
        end
      end

      EXEC: begin
        case (op_q)
          OP_R: begin
            alu_op     = 2'b10;
            state_next = WB;
          end
          OP_I: begin
            alu_src    = 1'b1;
            alu_op     = 2'b11;
            state_next = WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src    = 1'b1;
            alu_op     = 2'b00;
            state_next = MEM;
          end
          OP_BRANCH: begin
            alu_op     = 2'b01;
            pc_write   = 1'b1;
            pc_src     = (f3_q == F3_BNE) ? ~alu_zero : alu_zero;
            retire     = 1'b1;
            state_next = FETCH;
          end
          default: begin
            state_next = IDLE;
          end
        endcase
      end

      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ready) begin
          if (op_q == OP_STORE) begin
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end else begin
          state_next = MEM;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op_q == OP_LOAD);
        pc_write   = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule
